cond_unit: RTL and testbench

Condition/flag unit that consumes the 4-bit NZCV flags produced by the ALU and decides whether each instruction commits.
- Holds the architectural NZCV flag register and updates it under FlagW control.
- Evaluates the 4-bit condition field against the stored flags and gates PCSrc, RegWrite and MemWrite.
- Sits between decode/ALU and writeback, behind a one-entry registered output stage with valid/ready handshake.

---
 rtl/cond_unit_if.sv | 34 +++
 rtl/cond_unit.sv | 116 +++++++++++
 tb/tb_cond_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Instruction/result handshake bundle between decode/ALU, the condition unit and writeback.
// The master side presents instructions and accepts results; the slave side is the unit.
interface cond_unit_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       Cond;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagW;
  logic             PCS;
  logic             RegW;
  logic             MemW;
  logic             NoWrite;
  logic             out_valid;
  logic             out_ready;
  logic             PCSrc;
  logic             RegWrite;
  logic             MemWrite;
  logic             CondEx;
  logic [3:0]       Flags;
  logic             cnt_clr;
  logic [CNT_W-1:0] SquashCount;

  modport master (
    output in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready, cnt_clr,
    input  in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags, SquashCount
  );

  modport slave (
    input  in_valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, out_ready, cnt_clr,
    output in_ready, out_valid, PCSrc, RegWrite, MemWrite, CondEx, Flags, SquashCount
  );
endinterface

// File: rtl/cond_unit.sv
// Condition/flag unit: holds NZCV, evaluates the condition field against the stored flags
// and gates PC/register/memory writes behind a one-entry registered output stage.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic      clk,
  input  logic      reset,
  cond_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_reg;
  logic [3:0]       flags_next;
  logic             out_valid_reg;
  logic             pcsrc_reg;
  logic             regwrite_reg;
  logic             memwrite_reg;
  logic             condex_reg;
  logic [CNT_W-1:0] squash_cnt_reg;
  logic [CNT_W-1:0] squash_cnt_next;

  logic             in_ready;
  logic             accept;
  logic             cond_pass;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;

  assign flag_n = flags_reg[3];
  assign flag_z = flags_reg[2];
  assign flag_c = flags_reg[1];
  assign flag_v = flags_reg[0];

  assign in_ready = ~out_valid_reg | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  // Evaluated against the stored flags so back-to-back instructions see prior updates.
  always_comb begin
    cond_pass = 1'b0;
    case (bus.Cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = ~flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = ~flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = ~flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = ~flag_v;
      4'b1000: cond_pass = flag_c & ~flag_z;
      4'b1001: cond_pass = ~flag_c | flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = ~flag_z & (flag_n == flag_v);
      4'b1101: cond_pass = flag_z | (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // FlagW[1] covers N,Z (bits 3:2); FlagW[0] covers C,V (bits 1:0).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_flag
      assign flags_next[gi] = (accept & cond_pass & bus.FlagW[gi/2]) ?
                              bus.ALUFlags[gi] : flags_reg[gi];
    end
  endgenerate

  always_comb begin
    squash_cnt_next = squash_cnt_reg;
    if (bus.cnt_clr)
      squash_cnt_next = '0;
    else if (accept & ~cond_pass & (squash_cnt_reg != CNT_MAX))
      squash_cnt_next = squash_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg      <= 4'b0000;
      squash_cnt_reg <= '0;
    end else begin
      flags_reg      <= flags_next;
      squash_cnt_reg <= squash_cnt_next;
    end
  end

  // A drain alone only clears valid; the gated outputs keep their last values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      pcsrc_reg     <= 1'b0;
      regwrite_reg  <= 1'b0;
      memwrite_reg  <= 1'b0;
      condex_reg    <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      condex_reg    <= cond_pass;
      pcsrc_reg     <= bus.PCS & cond_pass;
      regwrite_reg  <= bus.RegW & ~bus.NoWrite & cond_pass;
      memwrite_reg  <= bus.MemW & cond_pass;
    end else if (bus.out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_reg;
  assign bus.PCSrc       = pcsrc_reg;
  assign bus.RegWrite    = regwrite_reg;
  assign bus.MemWrite    = memwrite_reg;
  assign bus.CondEx      = condex_reg;
  assign bus.Flags       = flags_reg;
  assign bus.SquashCount = squash_cnt_reg;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: a reference flag/condition model queues the expected
// result when an instruction is driven; it is popped and compared after the accepting edge.
module tb_cond_unit;

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = 2'd3;

  typedef struct packed {
    logic             ce;
    logic             pcs;
    logic             rw;
    logic             mw;
    logic [3:0]       flags;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [3:0]       model_flags;
  logic [CNT_W-1:0] model_cnt;
  exp_t             sb[$];
  exp_t             last;

  cond_unit_if #(.CNT_W(CNT_W)) bus ();

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    // Odd codes below 1110 are the inverse of the preceding even code.
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = !(n ^ v);
      3'd6: base = !z && !(n ^ v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  task automatic check_out(input string name, input exp_t e);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.CondEx !== e.ce || bus.PCSrc !== e.pcs ||
        bus.RegWrite !== e.rw || bus.MemWrite !== e.mw || bus.Flags !== e.flags ||
        bus.SquashCount !== e.cnt) begin
      fails++;
      $display("[TB] FAIL %s: got v=%b ce=%b pcs=%b rw=%b mw=%b flags=%b cnt=%0d, want v=1 ce=%b pcs=%b rw=%b mw=%b flags=%b cnt=%0d",
               name, bus.out_valid, bus.CondEx, bus.PCSrc, bus.RegWrite, bus.MemWrite,
               bus.Flags, bus.SquashCount, e.ce, e.pcs, e.rw, e.mw, e.flags, e.cnt);
    end else begin
      $display("[TB] ok %s: ce=%b pcs=%b rw=%b mw=%b flags=%b cnt=%0d",
               name, e.ce, e.pcs, e.rw, e.mw, e.flags, e.cnt);
    end
  endtask

  // Called #1 after a rising edge; the instruction is accepted on the next edge.
  task automatic send(input string name, input logic [3:0] c, input logic [3:0] af,
                      input logic [1:0] fw, input logic p, input logic r,
                      input logic m, input logic nw, input logic clr);
    exp_t e;
    logic ok;
    bus.Cond = c; bus.ALUFlags = af; bus.FlagW = fw;
    bus.PCS = p; bus.RegW = r; bus.MemW = m; bus.NoWrite = nw;
    bus.cnt_clr = clr; bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s in_ready: got %b want 1", name, bus.in_ready);
    end
    ok = ref_cond(c, model_flags);
    e.ce = ok; e.pcs = p & ok; e.rw = r & ~nw & ok; e.mw = m & ok;
    if (ok && fw[1]) model_flags[3:2] = af[3:2];
    if (ok && fw[0]) model_flags[1:0] = af[1:0];
    if (clr)                        model_cnt = '0;
    else if (!ok && model_cnt != CMAX) model_cnt = model_cnt + 1'b1;
    e.flags = model_flags; e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.cnt_clr = 1'b0; bus.FlagW = 2'b00;
    last = sb.pop_front();
    check_out(name, last);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.cnt_clr = 1'b0;
    bus.Cond = 4'b0; bus.ALUFlags = 4'b0; bus.FlagW = 2'b0;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    model_flags = 4'b0; model_cnt = '0; sb.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.Flags !== 4'b0000 || bus.in_ready !== 1'b1 ||
        bus.SquashCount !== '0 || bus.CondEx !== 1'b0 || bus.RegWrite !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state: got v=%b flags=%b rdy=%b cnt=%0d ce=%b rw=%b want 0 0000 1 0 0 0",
               bus.out_valid, bus.Flags, bus.in_ready, bus.SquashCount, bus.CondEx, bus.RegWrite);
    end else $display("[TB] ok reset_state");
  endtask

  task automatic test_basic();
    send("al_load_nz",  4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0, 0);
    tests++;
    if (bus.Flags !== 4'b0100 || bus.RegWrite !== 1'b1) begin
      fails++;
      $display("[TB] FAIL al_load_const: got flags=%b rw=%b want 0100 1", bus.Flags, bus.RegWrite);
    end
    send("eq_memw",     4'b0000, 4'b1111, 2'b00, 0, 0, 1, 0, 0);
    send("ne_squash",   4'b0001, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
    tests++;
    if (bus.CondEx !== 1'b0 || bus.SquashCount !== 2'd1 || bus.Flags !== 4'b0100) begin
      fails++;
      $display("[TB] FAIL ne_squash_const: got ce=%b cnt=%0d flags=%b want 0 1 0100",
               bus.CondEx, bus.SquashCount, bus.Flags);
    end
    send("al_nowrite",  4'b1110, 4'b0000, 2'b00, 1, 1, 0, 1, 0);
    // Idle cycle with FlagW set but no in_valid: drains, flags untouched.
    bus.FlagW = 2'b11; bus.ALUFlags = 4'b1011;
    @(posedge clk); #1;
    bus.FlagW = 2'b00;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.Flags !== model_flags) begin
      fails++;
      $display("[TB] FAIL idle_drain: got v=%b flags=%b want v=0 flags=%b",
               bus.out_valid, bus.Flags, model_flags);
    end else $display("[TB] ok idle_drain");
  endtask

  task automatic test_flags();
    send("al_cv_only",  4'b1110, 4'b1011, 2'b01, 0, 1, 0, 0, 0);
    tests++;
    if (bus.Flags !== 4'b0111) begin
      fails++;
      $display("[TB] FAIL cv_only_const: got flags=%b want 0111", bus.Flags);
    end
    send("hi",          4'b1000, 4'b0000, 2'b11, 1, 0, 0, 0, 0);
    send("ge",          4'b1010, 4'b0000, 2'b11, 0, 1, 0, 0, 0);
    send("le",          4'b1101, 4'b1000, 2'b10, 1, 1, 1, 0, 0);
    send("lt",          4'b1011, 4'b0011, 2'b11, 0, 1, 0, 0, 0);
    send("gt",          4'b1100, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
    send("cc",          4'b0011, 4'b0000, 2'b00, 0, 0, 1, 0, 0);
  endtask

  task automatic test_stall();
    send("pre_stall",   4'b1110, 4'b0010, 2'b11, 1, 1, 1, 0, 0);
    bus.out_ready = 1'b0;
    bus.Cond = 4'b1110; bus.ALUFlags = 4'b1111; bus.FlagW = 2'b11;
    bus.PCS = 1'b0; bus.RegW = 1'b0; bus.MemW = 1'b0; bus.NoWrite = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.in_ready !== 1'b0) begin
        fails++;
        $display("[TB] FAIL stall_ready%0d: got %b want 0", i, bus.in_ready);
      end
      @(posedge clk); #1;
      check_out($sformatf("stall_hold%0d", i), last);
    end
    bus.out_ready = 1'b1;
    send("drain_accept", 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.Flags !== 4'b0000 || bus.PCSrc !== 1'b0 ||
        bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset: got v=%b flags=%b pcs=%b rw=%b mw=%b want all 0",
               bus.out_valid, bus.Flags, bus.PCSrc, bus.RegWrite, bus.MemWrite);
    end else $display("[TB] ok async_reset");
    model_flags = 4'b0; model_cnt = '0; sb.delete();
    @(posedge clk); #1 reset = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL post_reset_ready: got rdy=%b v=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_squash_sat();
    for (int i = 0; i < 5; i++)
      send($sformatf("nv_sat%0d", i), 4'b1111, 4'b1111, 2'b11, 1, 1, 1, 0, 0);
    tests++;
    if (bus.SquashCount !== 2'd3) begin
      fails++;
      $display("[TB] FAIL sat_const: got %0d want 3", bus.SquashCount);
    end
    send("clr_wins",    4'b1111, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
    send("after_clr",   4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++)
      send($sformatf("rand%0d", i), 4'($urandom_range(15)), 4'($urandom_range(15)),
           2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
           1'($urandom_range(1)), 1'($urandom_range(1)), (i == 17));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_flags();
    test_stall();
    test_reset_mid();
    test_squash_sat();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
